// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART (TXD/RXD/CON registers) with a shared baud divider.
// Optional feature macro: UART_CTRL_IRQ_EN enables CON[1:0] interrupt enables and the irq output.
module uart_ctrl #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  localparam int unsigned CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [1:0] A_TXD = 2'd0;
  localparam logic [1:0] A_RXD = 2'd1;
  localparam logic [1:0] A_CON = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic txd_wr_c, con_wr_c, rxd_rd_c, con_rd_c;
  assign txd_wr_c = wr && (addr == A_TXD);
  assign con_wr_c = wr && (addr == A_CON);
  assign rxd_rd_c = rd && (addr == A_RXD);
  assign con_rd_c = rd && (addr == A_CON);

  // Transmit engine
  state_t        tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_busy, tx_busy_n, tx_done, tx_done_n, tx_line_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_busy  <= tx_busy_n;
      tx_done  <= tx_done_n;
      uart_tx  <= tx_line_n;
    end
  end

  // tx_line_n is the line level for the state being entered, so uart_tx lags the write by one edge
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_busy_n  = tx_busy;
    tx_done_n  = tx_done && !con_rd_c;
    tx_line_n  = uart_tx;
    case (tx_state)
      S_IDLE: begin
        if (tx_busy) begin
          tx_state_n = S_START;
          tx_cnt_n   = '0;
          tx_line_n  = 1'b0;
        end else if (txd_wr_c) begin
          tx_shift_n = wdata;
          tx_busy_n  = 1'b1;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_state_n = S_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n  = tx_bit + 3'd1;
            tx_line_n = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = S_IDLE;
          tx_cnt_n   = '0;
          tx_busy_n  = 1'b0;
          tx_done_n  = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // Receive engine behind a 2-flop synchronizer; rx_prev detects the start-bit falling edge
  logic          rx_s1, rx_s2, rx_prev;
  state_t        rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n, rxd, rxd_n;
  logic          rx_valid, rx_valid_n, rx_ovr, rx_ovr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rxd      <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rxd      <= rxd_n;
      rx_valid <= rx_valid_n;
      rx_ovr   <= rx_ovr_n;
    end
  end

  // A framing error simply returns to IDLE: no new falling edge occurs until the line goes high again
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rxd_n      = rxd;
    rx_valid_n = rx_valid && !rxd_rd_c;
    rx_ovr_n   = rx_ovr && !(con_wr_c && wdata[5]);
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = S_START;
          rx_cnt_n   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = S_IDLE;
          rx_cnt_n   = '0;
          if (rx_s2) begin
            rxd_n      = rx_shift;
            rx_valid_n = 1'b1;
            if (rx_valid && !rxd_rd_c) rx_ovr_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  logic [1:0] irq_en;
`ifdef UART_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)         irq_en <= 2'b00;
    else if (con_wr_c) irq_en <= wdata[1:0];
  end
  assign irq = (irq_en[0] & rx_valid) | (irq_en[1] & tx_done);
`else
  assign irq_en = 2'b00;
  assign irq    = 1'b0;
`endif

  // TXD is write-only and the reserved slot reads 0
  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (addr)
        A_RXD:   rdata = rxd;
        A_CON:   rdata = {2'b00, rx_ovr, tx_busy, rx_valid, tx_done, irq_en};
        default: rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: randomized self-checking bench for uart_ctrl at BAUD_DIV = 16.
// Expectations follow UART_CTRL_IRQ_EN when it is defined for the build.
module tb_uart_ctrl;
  localparam int BAUD = 16;

  logic       clk, reset, rd, wr, uart_rx, uart_tx, irq;
  logic [1:0] addr;
  logic [7:0] wdata, rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the register-visible state
  logic [1:0] m_en;
  logic       m_done, m_valid, m_ovr;
  logic [7:0] m_rxd;

  uart_ctrl #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_con(input logic busy);
    return {2'b00, m_ovr, busy, m_valid, m_done, m_en};
  endfunction

  function automatic logic m_irq();
    return (m_en[0] & m_valid) | (m_en[1] & m_done);
  endfunction

  // Line level i cycles after the edge that samples a TXD write
  function automatic logic tx_expect(input logic [7:0] b, input int i);
    int slot;
    if (i < 1) return 1'b1;
    slot = (i - 1) / BAUD;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic con_write(input logic [7:0] d);
    reg_write(2'd2, d);
`ifdef UART_CTRL_IRQ_EN
    m_en = d[1:0];
`endif
    if (d[5]) m_ovr = 1'b0;
  endtask

  task automatic con_check(input string tag);
    logic [7:0] v;
    reg_read(2'd2, v);
    check(tag, 32'(v), 32'(m_con(1'b0)));
    m_done = 1'b0;
  endtask

  task automatic rxd_check(input string tag);
    logic [7:0] v;
    reg_read(2'd1, v);
    check(tag, 32'(v), 32'(m_rxd));
    m_valid = 1'b0;
  endtask

  // Sends one frame, polling CON every cycle; busy_at > 0 injects an ignored TXD write at that cycle
  task automatic tx_frame(input logic [7:0] b, input int busy_at);
    bit line_ok = 1'b1;
    bit con_ok  = 1'b1;
    int bad;
    reg_write(2'd0, b);
    rd = 1'b1; addr = 2'd2;
    #1;
    check("tx_line_start", 32'(uart_tx), 32'(1'b1));
    check("tx_con_start", 32'(rdata), 32'(m_con(1'b1)));
    m_done = 1'b0;
    for (int i = 1; i <= 165; i++) begin
      @(negedge clk);
      wr = 1'b0; rd = (i <= 161); addr = 2'd2;
      if (i == busy_at) begin
        rd = 1'b0; addr = 2'd0; wr = 1'b1; wdata = 8'hFF;
      end
      #1;
      if (line_ok) begin
        bad = n_fail;
        check("tx_line", 32'(uart_tx), 32'(tx_expect(b, i)));
        line_ok = (bad == n_fail);
      end
      if (i == 161) begin
        m_done = 1'b1;
        check("tx_con_end", 32'(rdata), 32'(m_con(1'b0)));
        rd = 1'b0;
      end else if (rd && con_ok) begin
        bad = n_fail;
        check("tx_con_busy", 32'(rdata), 32'(m_con(1'b1)));
        con_ok = (bad == n_fail);
      end
    end
    rd = 1'b0; addr = 2'd0;
    check("tx_irq", 32'(irq), 32'(m_irq()));
  endtask

  task automatic tx_reset(input logic [7:0] b, input int at);
    bit line_ok = 1'b1;
    int bad;
    reg_write(2'd0, b);
    for (int i = 1; i <= at; i++) begin
      @(negedge clk);
      #1;
      if (line_ok) begin
        bad = n_fail;
        check("rst_frame_line", 32'(uart_tx), 32'(tx_expect(b, i)));
        line_ok = (bad == n_fail);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    rd = 1'b1; addr = 2'd2;
    #1;
    check("rst_mid_tx", 32'(uart_tx), 32'(1'b1));
    check("rst_mid_con", 32'(rdata), 32'(8'h00));
    check("rst_mid_irq", 32'(irq), 32'(1'b0));
    reset = 1'b0; rd = 1'b0;
    m_en = 2'b00; m_done = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_rxd = 8'h00;
    repeat (40) @(negedge clk);
    check("rst_idle_tx", 32'(uart_tx), 32'(1'b1));
    con_check("rst_idle_con");
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (BAUD) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_rxd   = b;
    end
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 8'h00; uart_rx = 1'b1;
    m_en = 2'b00; m_done = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_rxd = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", 32'(uart_tx), 32'(1'b1));
    check("rst_irq", 32'(irq), 32'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    con_check("rst_con");
    rxd_check("rst_rxd");

    tx_frame(8'h55, 0);
    con_check("tx_done_read");
    con_check("tx_done_clr");

    rx_frame(8'hA3, 1'b1);
    con_check("rx_valid_set");
    rxd_check("rx_a3");
    con_check("rx_valid_clr");

    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    con_check("ovr_set");
    rxd_check("ovr_rxd");
    con_write(8'h20);
    con_check("ovr_clr");

    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    con_check("noise_con");
    rx_frame(8'($urandom), 1'b0);
    con_check("frame_err_con");
    rx_frame(8'($urandom), 1'b1);
    rxd_check("frame_err_recover");

    con_write(8'h01);
    rx_frame(8'h7E, 1'b1);
    check("irq_rx_set", 32'(irq), 32'(m_irq()));
    con_check("irq_rx_con");
    rxd_check("irq_rx_7e");
    check("irq_rx_clr", 32'(irq), 32'(m_irq()));
    con_write(8'h02);
    tx_frame(8'($urandom), 0);
    con_check("irq_tx_con");
    check("irq_tx_clr", 32'(irq), 32'(m_irq()));

    con_write(8'($urandom_range(0, 3)));
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 2))
        0: tx_frame(8'($urandom), ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 150)) : 0);
        1: begin
          rx_frame(8'($urandom), 1'b1);
          if ($urandom_range(0, 1) != 0) rxd_check("rand_rxd");
        end
        default: con_check("rand_con");
      endcase
      check("rand_irq", 32'(irq), 32'(m_irq()));
    end
    con_check("rand_con_final");
    rxd_check("rand_rxd_final");

    tx_frame(8'($urandom), 40);
    con_check("busy_wr_con");

    tx_reset(8'hF0, 50);
    tx_frame(8'($urandom), 0);
    con_check("post_rst_con");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
